// File: rtl/branch_resolution_queue_pkg.sv
// Shared types for the branch resolution queue: entry record and wrap-bit pointer.
// Module parameters default to these widths and must stay equal to them.
package branch_resolution_queue_pkg;
    localparam int BRQ_BW_ADDRESS         = 32;
    localparam int BRQ_NUM_GLOBAL_HISTORY = 4;
    localparam int BRQ_NUM_ENTRY          = 8;
    localparam int BRQ_BW_TAG             = $clog2(BRQ_NUM_ENTRY);

    // MSB is the wrap bit; the low bits index the entry array.
    typedef logic [BRQ_BW_TAG:0] brq_ptr_t;

    typedef struct packed {
        logic                              valid;
        logic                              resolved;
        logic [BRQ_BW_ADDRESS-1:0]         pc;
        logic [BRQ_BW_ADDRESS-1:0]         predicted_next;
        logic [BRQ_BW_ADDRESS-1:0]         correct_next;
        logic [BRQ_NUM_GLOBAL_HISTORY-1:0] history;
    } brq_entry_t;
endpackage

// File: rtl/branch_resolution_age_mask.sv
// Marks every slot strictly younger than the resolved tag, measuring age from the head.
module branch_resolution_age_mask
    import branch_resolution_queue_pkg::*;
#(
    parameter int NUM_ENTRY = BRQ_NUM_ENTRY,
    parameter int BW_TAG    = $clog2(NUM_ENTRY)
) (
    input  logic [BW_TAG-1:0]    head_idx,
    input  logic [BW_TAG-1:0]    tag,
    output logic [NUM_ENTRY-1:0] younger_mask
);
    logic [BW_TAG-1:0] tag_age;

    // Modular subtraction works because NUM_ENTRY is a power of two.
    assign tag_age = tag - head_idx;

    for (genvar g = 0; g < NUM_ENTRY; g++) begin : g_age
        logic [BW_TAG-1:0] slot_age;
        assign slot_age        = BW_TAG'(g) - head_idx;
        assign younger_mask[g] = slot_age > tag_age;
    end
endmodule

// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted branches: out-of-order resolve, mispredict rewind/flush,
// and in-order drain of resolved entries to the predictor.
module branch_resolution_queue
    import branch_resolution_queue_pkg::*;
#(
    parameter int BW_ADDRESS         = BRQ_BW_ADDRESS,
    parameter int NUM_GLOBAL_HISTORY = BRQ_NUM_GLOBAL_HISTORY,
    parameter int NUM_ENTRY          = BRQ_NUM_ENTRY,
    parameter int BW_TAG             = $clog2(NUM_ENTRY)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_alloc_valid,
    output logic                          o_alloc_ready,
    input  logic [BW_ADDRESS-1:0]         i_alloc_pc,
    input  logic [BW_ADDRESS-1:0]         i_alloc_predicted_pc_next,
    input  logic [NUM_GLOBAL_HISTORY-1:0] i_alloc_global_history,
    output logic [BW_TAG-1:0]             o_alloc_tag,
    input  logic                          i_resolve_valid,
    input  logic [BW_TAG-1:0]             i_resolve_tag,
    input  logic [BW_ADDRESS-1:0]         i_resolve_correct_pc_next,
    output logic                          o_flush_valid,
    output logic [BW_ADDRESS-1:0]         o_flush_pc,
    output logic                          o_branch_valid,
    input  logic                          i_branch_ready,
    output logic [BW_ADDRESS-1:0]         o_branch_pc,
    output logic [BW_ADDRESS-1:0]         o_branch_correct_pc_next,
    output logic [NUM_GLOBAL_HISTORY-1:0] o_branch_global_history,
    output logic                          o_branch_correct_prediction
);
    brq_entry_t [NUM_ENTRY-1:0] entries;
    brq_ptr_t                   head, tail, rewind_tail;
    logic [BW_TAG-1:0]          head_idx, tail_idx, res_age;
    brq_entry_t                 head_entry, res_entry;
    logic [NUM_ENTRY-1:0]       younger_mask;
    logic                       empty, full, alloc_fire, drain_fire, res_ok, mispredict;

    assign head_idx = head[BW_TAG-1:0];
    assign tail_idx = tail[BW_TAG-1:0];
    assign empty    = head == tail;
    assign full     = (head_idx == tail_idx) && (head[BW_TAG] != tail[BW_TAG]);

    assign o_alloc_ready = !full && !o_flush_valid;
    assign o_alloc_tag   = tail_idx;
    assign alloc_fire    = i_alloc_valid && o_alloc_ready;

    assign res_entry  = entries[i_resolve_tag];
    assign res_ok     = i_resolve_valid && res_entry.valid && !res_entry.resolved;
    assign mispredict = res_ok && (i_resolve_correct_pc_next != res_entry.predicted_next);

    // Rebuild the tag's full pointer from the head so the wrap bit comes out right.
    assign res_age     = i_resolve_tag - head_idx;
    assign rewind_tail = head + brq_ptr_t'(res_age) + brq_ptr_t'(1);

    assign head_entry                  = entries[head_idx];
    assign o_branch_valid              = !empty && head_entry.valid && head_entry.resolved;
    assign o_branch_pc                 = head_entry.pc;
    assign o_branch_correct_pc_next    = head_entry.correct_next;
    assign o_branch_global_history     = head_entry.history;
    assign o_branch_correct_prediction = head_entry.predicted_next == head_entry.correct_next;
    assign drain_fire                  = o_branch_valid && i_branch_ready;

    branch_resolution_age_mask #(.NUM_ENTRY(NUM_ENTRY), .BW_TAG(BW_TAG)) u_age_mask (
        .head_idx     (head_idx),
        .tag          (i_resolve_tag),
        .younger_mask (younger_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            o_flush_valid <= 1'b0;
            o_flush_pc    <= '0;
        end else begin
            if (drain_fire) head <= head + brq_ptr_t'(1);
            // Rewind wins over allocation: a same-cycle alloc is younger and gets squashed.
            if (mispredict)      tail <= rewind_tail;
            else if (alloc_fire) tail <= tail + brq_ptr_t'(1);
            o_flush_valid <= mispredict;
            if (mispredict) o_flush_pc <= i_resolve_correct_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                if (alloc_fire && tail_idx == BW_TAG'(i)) begin
                    entries[i].valid          <= 1'b1;
                    entries[i].resolved       <= 1'b0;
                    entries[i].pc             <= i_alloc_pc;
                    entries[i].predicted_next <= i_alloc_predicted_pc_next;
                    entries[i].correct_next   <= '0;
                    entries[i].history        <= i_alloc_global_history;
                end
                if (res_ok && i_resolve_tag == BW_TAG'(i)) begin
                    entries[i].resolved     <= 1'b1;
                    entries[i].correct_next <= i_resolve_correct_pc_next;
                end
                if (mispredict && younger_mask[i]) entries[i].valid <= 1'b0;
                if (drain_fire && head_idx == BW_TAG'(i)) entries[i].valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed and random checks of branch_resolution_queue against a program-order queue model.
module tb_branch_resolution_queue;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_alloc_valid = 1'b0;
    logic        o_alloc_ready;
    logic [31:0] i_alloc_pc = '0;
    logic [31:0] i_alloc_predicted_pc_next = '0;
    logic [3:0]  i_alloc_global_history = '0;
    logic [2:0]  o_alloc_tag;
    logic        i_resolve_valid = 1'b0;
    logic [2:0]  i_resolve_tag = '0;
    logic [31:0] i_resolve_correct_pc_next = '0;
    logic        o_flush_valid;
    logic [31:0] o_flush_pc;
    logic        o_branch_valid;
    logic        i_branch_ready = 1'b0;
    logic [31:0] o_branch_pc;
    logic [31:0] o_branch_correct_pc_next;
    logic [3:0]  o_branch_global_history;
    logic        o_branch_correct_prediction;

    always #5 clk = ~clk;

    branch_resolution_queue dut (
        .clk(clk), .rst_n(rst_n),
        .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready),
        .i_alloc_pc(i_alloc_pc), .i_alloc_predicted_pc_next(i_alloc_predicted_pc_next),
        .i_alloc_global_history(i_alloc_global_history), .o_alloc_tag(o_alloc_tag),
        .i_resolve_valid(i_resolve_valid), .i_resolve_tag(i_resolve_tag),
        .i_resolve_correct_pc_next(i_resolve_correct_pc_next),
        .o_flush_valid(o_flush_valid), .o_flush_pc(o_flush_pc),
        .o_branch_valid(o_branch_valid), .i_branch_ready(i_branch_ready),
        .o_branch_pc(o_branch_pc), .o_branch_correct_pc_next(o_branch_correct_pc_next),
        .o_branch_global_history(o_branch_global_history),
        .o_branch_correct_prediction(o_branch_correct_prediction)
    );

    // Model: live entries in program order, element 0 is the head.
    typedef struct {
        logic [31:0] pc, pred, corr;
        logic [3:0]  hist;
        bit          res;
    } ment_t;

    ment_t       mq[$];
    int          mhead = 0;
    bit          mflush = 0;
    logic [31:0] mflush_pc = '0;
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_alloc_valid = 0; i_resolve_valid = 0; i_branch_ready = 0;
        #1;
        chk("rst_ready", o_alloc_ready, 1);
        chk("rst_flush", o_flush_valid, 0);
        chk("rst_flush_pc", o_flush_pc, 0);
        chk("rst_bvalid", o_branch_valid, 0);
        chk("rst_tag", o_alloc_tag, 0);
        mq.delete(); mhead = 0; mflush = 0; mflush_pc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_tag_after", o_alloc_tag, 0);
    endtask

    // Called just after a rising edge: drive, compare against the model, then advance one cycle.
    task automatic step(input bit av, input logic [31:0] apc, input logic [31:0] apred,
                        input logic [3:0] ahist, input bit rv, input int rtag,
                        input logic [31:0] rcorr, input bit br);
        bit    full, ready, bvalid, afire, dfire, rok, mis;
        int    k;
        ment_t e;
        i_alloc_valid = av; i_alloc_pc = apc; i_alloc_predicted_pc_next = apred;
        i_alloc_global_history = ahist; i_resolve_valid = rv; i_resolve_tag = 3'(rtag);
        i_resolve_correct_pc_next = rcorr; i_branch_ready = br;
        #1;
        full   = mq.size() == N;
        ready  = !full && !mflush;
        bvalid = mq.size() > 0 && mq[0].res;
        chk("alloc_ready", o_alloc_ready, ready);
        chk("alloc_tag", o_alloc_tag, (mhead + mq.size()) % N);
        chk("flush_valid", o_flush_valid, mflush);
        if (mflush) chk("flush_pc", o_flush_pc, mflush_pc);
        chk("branch_valid", o_branch_valid, bvalid);
        if (bvalid) begin
            chk("branch_pc", o_branch_pc, mq[0].pc);
            chk("branch_corr", o_branch_correct_pc_next, mq[0].corr);
            chk("branch_hist", o_branch_global_history, mq[0].hist);
            chk("branch_ok", o_branch_correct_prediction, mq[0].pred == mq[0].corr);
        end
        afire = av && ready;
        dfire = bvalid && br;
        k     = (rtag - mhead + N) % N;
        rok   = rv && k < mq.size() && !mq[k].res;
        mis   = rok && (rcorr != mq[k].pred);
        @(posedge clk);
        if (rok) begin mq[k].res = 1; mq[k].corr = rcorr; end
        if (afire) begin
            e.pc = apc; e.pred = apred; e.corr = '0; e.hist = ahist; e.res = 0;
            mq.push_back(e);
        end
        if (mis) while (mq.size() > k + 1) void'(mq.pop_back());
        if (dfire) begin void'(mq.pop_front()); mhead = (mhead + 1) % N; end
        mflush = mis;
        if (mis) mflush_pc = rcorr;
        #1;
    endtask

    task automatic idle(input bit br);
        step(0, 0, 0, 0, 0, 0, 0, br);
    endtask

    initial begin
        // Simple correct prediction reaches the predictor one cycle after resolve.
        do_reset();
        step(1, 'h100, 'h104, 4'b0011, 0, 0, 0, 1);
        chk("t1_tag", o_alloc_tag, 1);
        step(0, 0, 0, 0, 1, 0, 'h104, 0);
        chk("t1_bvalid", o_branch_valid, 1);
        chk("t1_ok", o_branch_correct_prediction, 1);
        chk("t1_hist", o_branch_global_history, 4'b0011);
        chk("t1_noflush", o_flush_valid, 0);
        idle(1);
        chk("t1_drained", o_branch_valid, 0);

        // Out-of-order resolves drain in program order.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 'h200 + i*16, 'h204 + i*16, 4'(i), 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 2, 'h224, 1);
        chk("t2_hold", o_branch_valid, 0);
        step(0, 0, 0, 0, 1, 0, 'h204, 1);
        chk("t2_v0", o_branch_valid, 1);
        chk("t2_pc0", o_branch_pc, 'h200);
        idle(1);
        chk("t2_wait1", o_branch_valid, 0);
        step(0, 0, 0, 0, 1, 1, 'h214, 1);
        chk("t2_pc1", o_branch_pc, 'h210);
        idle(1);
        chk("t2_v2", o_branch_valid, 1);
        chk("t2_pc2", o_branch_pc, 'h220);
        idle(1);
        chk("t2_empty", o_branch_valid, 0);

        // Mispredict on tag1 with a same-cycle alloc that must be squashed.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 'h300 + i*16, 'h304 + i*16, 0, 0, 0, 0, 0);
        step(1, 'h400, 'h404, 0, 1, 1, 'h200, 0);
        chk("t3_flush", o_flush_valid, 1);
        chk("t3_flush_pc", o_flush_pc, 'h200);
        chk("t3_tag", o_alloc_tag, 2);
        chk("t3_ready_blk", o_alloc_ready, 0);
        idle(0);
        chk("t3_flush_off", o_flush_valid, 0);
        chk("t3_ready", o_alloc_ready, 1);
        step(1, 'h500, 'h504, 0, 0, 0, 0, 0);
        chk("t3_tag_next", o_alloc_tag, 3);

        // Full queue, drain one, next alloc wraps to tag 0.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 'h600 + i*16, 'h604 + i*16, 4'(i), 0, 0, 0, 0);
        chk("t4_full", o_alloc_ready, 0);
        chk("t4_tag", o_alloc_tag, 0);
        step(1, 'h700, 'h704, 0, 1, 0, 'h604, 0);
        step(1, 'h700, 'h704, 0, 0, 0, 0, 1);
        chk("t4_ready", o_alloc_ready, 1);
        chk("t4_wrap", o_alloc_tag, 0);
        step(1, 'h700, 'h704, 0, 0, 0, 0, 0);
        chk("t4_tag1", o_alloc_tag, 1);
        chk("t4_full2", o_alloc_ready, 0);

        // Backpressure: head held stable until the predictor accepts.
        step(0, 0, 0, 0, 1, 1, 'h614, 0);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("t5_hold", o_branch_valid, 1);
            chk("t5_pc", o_branch_pc, 'h610);
        end
        idle(1);
        chk("t5_popped", o_branch_valid, 0);

        // Reset with live entries and a pending flush pulse.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 'h800 + i*16, 'h804 + i*16, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 'h814, 0);
        step(0, 0, 0, 0, 1, 3, 'h999, 0);
        chk("t6_flush_pending", o_flush_valid, 1);
        do_reset();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            bit          av, rv, br;
            int          rtag;
            logic [31:0] apc, rcorr;
            av  = ($urandom % 100) < 60;
            rv  = ($urandom % 100) < 50;
            br  = ($urandom % 100) < 70;
            apc = $urandom & 32'hffff_fffc;
            if (mq.size() > 0 && ($urandom % 4) != 0) rtag = (mhead + int'($urandom % mq.size())) % N;
            else rtag = int'($urandom % N);
            rcorr = $urandom & 32'hffff_fffc;
            if ((rtag - mhead + N) % N < mq.size() && ($urandom % 4) != 0)
                rcorr = mq[(rtag - mhead + N) % N].pred;
            step(av, apc, apc + 4, 4'($urandom), rv, rtag, rcorr, br);
            if (c == 2000) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolution_queue.md
Name: branch_resolution_queue

Overview:
- Producer side of the predictor's branch-update interface.
- Records every predicted control-flow instruction at fetch/decode: PC, predicted next PC and global history snapshot.
- Accepts out-of-order resolutions from the branch unit and issues a one-cycle redirect/flush on a misprediction.
- Drains resolved entries in program order to the predictor as i_branch_* updates.

Parameters:
- BW_ADDRESS, 32, PC width
- NUM_GLOBAL_HISTORY, 4, global history width; must match the predictor
- NUM_ENTRY, 8, queue depth; power of two, ≥2
- BW_TAG, $clog2(NUM_ENTRY), entry tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_alloc_valid  in  1  allocation request
- o_alloc_ready  out  1  allocation accepted when high with valid
- i_alloc_pc  in  BW_ADDRESS  branch PC
- i_alloc_predicted_pc_next  in  BW_ADDRESS  predicted next PC
- i_alloc_global_history  in  NUM_GLOBAL_HISTORY  history used for the prediction
- o_alloc_tag  out  BW_TAG  tag given to the accepted entry (= tail index)
- i_resolve_valid  in  1  branch unit result
- i_resolve_tag  in  BW_TAG  entry being resolved
- i_resolve_correct_pc_next  in  BW_ADDRESS  actual next PC
- o_flush_valid  out  1  one-cycle redirect pulse
- o_flush_pc  out  BW_ADDRESS  redirect target
- o_branch_valid  out  1  update to predictor
- i_branch_ready  in  1  predictor accepts update
- o_branch_pc  out  BW_ADDRESS  head PC
- o_branch_correct_pc_next  out  BW_ADDRESS  head actual next PC
- o_branch_global_history  out  NUM_GLOBAL_HISTORY  head history snapshot
- o_branch_correct_prediction  out  1  head predicted == actual

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Storage: circular buffer. head/tail pointers are BW_TAG+1 bits; the MSB is the wrap bit.
  - empty when head==tail.
  - full when indices are equal and wrap bits differ.
- Per-entry state: valid, resolved, pc, predicted_next, correct_next, history.
- Reset clears pointers and all valid/resolved bits. Outputs after reset: o_alloc_ready=1, o_flush_valid=0, o_branch_valid=0, o_flush_pc=0, o_alloc_tag=0.
- Allocation:
  - o_alloc_ready = !full && !o_flush_valid.
  - Handshake on valid&&ready: write the entry at the tail with valid=1, resolved=0, then advance the tail.
  - o_alloc_tag = tail index, combinational.
- Resolution:
  - Ignored if the tagged entry is not valid, or is already resolved (double resolve).
  - Otherwise store correct_next and set resolved=1 at the next edge.
  - mispredict = correct_next != predicted_next.
  - On mispredict, at the next edge:
    - Invalidate every entry younger than the tag.
    - Set tail = tag+1, keeping the correct wrap bit.
    - Register o_flush_valid=1 and o_flush_pc=correct_next for exactly one cycle.
  - The resolved entry itself stays and drains normally.
- Flush contract: the branch unit drops all younger in-flight resolves on o_flush_valid. A resolve targeting a squashed tag after the flush is a protocol violation and is not checked.
- Drain:
  - o_branch_valid = !empty && head.valid && head.resolved.
  - o_branch_* are driven from the head entry.
  - o_branch_correct_prediction = head.predicted_next == head.correct_next.
  - On valid&&ready: clear head.valid and advance the head.
  - Latency from resolve to o_branch_valid is 1 cycle when the entry is at the head.
- Simultaneous events:
  - Alloc and drain in the same cycle are both honoured. When full, the slot freed by the drain is not reusable until the next cycle, because ready is computed from the current full flag.
  - A resolve of the head and a drain of the head in the same cycle: the drain is not yet visible (resolved=0), so it completes next cycle.
  - Mispredict resolve in the same cycle as an alloc: alloc is accepted (ready uses the registered flush). The newly allocated entry is younger and is squashed by the tail rewind, because the rewind has priority over the tail increment.
- Wrap-around: all tag/age comparisons use age = (tag - head) mod NUM_ENTRY.
- Reset mid-operation discards all entries with no flush pulse.

Decomposition:
- Shared package holds:
  - branch entry struct: valid, resolved, pc, predicted_next, correct_next, history.
  - pointer typedef with wrap bit.
- Natural sub-module: branch_resolution_age_mask. Combinational; it takes head, tag and NUM_ENTRY and produces the younger-than-tag invalidate mask.

Test Plan:
1. Reset, then allocate pc=0x100/pred=0x104/hist=4'b0011 and resolve tag0 with correct=0x104. Expect o_branch_valid next cycle with correct_prediction=1 and hist=4'b0011, no flush.
2. Allocate tags 0..2, resolve tag2 then tag0 (both correct). Expect no update while tag0 is unresolved. Then expect updates in order 0, then 2 only after tag1 resolves, with i_branch_ready held high.
3. Allocate tags 0..3, resolve tag1 with correct=0x200 ≠ predicted. Expect o_flush_valid one cycle with o_flush_pc=0x200, tail=2, entries 2 and 3 invalid, next o_alloc_tag=2.
4. Allocate 8 entries. Expect o_alloc_ready=0. Resolve and drain one; expect ready=1 the following cycle and the new tag wraps to 0.
5. With i_branch_ready=0, resolve the head. Expect o_branch_valid held with stable data until ready rises, then a single pop.
6. Assert rst_n low mid-stream with 5 entries live. Expect all outputs at reset values immediately, and o_alloc_tag=0 after release.
